mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between instruction fetch (IF) and the MEM stage's data accesses.
- Sequences each access through a fixed-latency memory and performs sub-word lane steering: byte enables, store replication, and load right-shift.
- Load data leaves the block right-aligned, ready for the MEM stage's LB/LH/LW sign extension.
- Data has priority over fetch; a fairness counter bounds fetch starvation.

Parameters:
- LATENCY, 2, cycles from mem_req to valid mem_rdata (≥1).
- FAIR_LIMIT, 4, consecutive data grants with if_req pending before fetch is forced.

Ports:
- clock in 1: single clock, all state on posedge.
- reset in 1: synchronous, active-low.
- if_req in 1: fetch request, held until if_ready.
- if_addr in 32: fetch byte address (word-aligned).
- if_ready out 1: one-cycle completion pulse.
- if_rdata out 32: fetched instruction.
- d_req in 1: data request, held until d_ready.
- d_we in 1: 1 = store.
- d_addr in 32: data byte address.
- d_wdata in 32: store data, low-aligned.
- d_funct3 in 3: access size code.
- d_ready out 1: one-cycle completion pulse.
- d_rdata out 32: load data, right-aligned, not extended.
- d_err out 1: misaligned/illegal size, valid with d_ready.
- mem_req out 1: one-cycle access strobe.
- mem_we out 1: write enable.
- mem_addr out 32: word address, bits [1:0] = 0.
- mem_wdata out 32: lane-replicated write data.
- mem_be out 4: byte enables.
- mem_rdata in 32: read data, valid LATENCY cycles after mem_req.
- stall_if out 1: if_req && !if_ready.
- stall_mem out 1: d_req && !d_ready.

Behaviour:
- Reset (reset=0 at posedge):
  - FSM goes to IDLE; fairness counter and latency counter clear.
  - All registered outputs go to 0: ready pulses, rdata, d_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata.
  - Reset during ISSUE/WAIT/DONE abandons the transaction; no ready pulse is produced.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE arbitration:
  - Data wins if d_req, unless if_req && fair_cnt==FAIR_LIMIT, in which case fetch wins.
  - On grant, latch owner, word address, we, be, wdata and funct3, then go to ISSUE.
  - No request: stay in IDLE.
- IDLE misaligned data request: no memory access; go to DONE with d_err=1 and d_rdata=0.
- Size decode (d_funct3):
  - 000 / 100: byte.
  - 001 / 101: half; misaligned if addr[0]=1.
  - 010: word; misaligned if addr[1:0]≠0.
  - Any other code: d_err.
- Store steering:
  - Byte: be = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - Half: be = 0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - Word: be = 1111.
- Fetch accesses: always be = 1111, we = 0.
- ISSUE (one cycle):
  - mem_req=1; mem_addr/we/be/wdata are valid in this cycle only.
  - Store: go to DONE (posted write).
  - Load/fetch: load lat_cnt=LATENCY-1 and go to WAIT.
- WAIT:
  - Decrement lat_cnt each cycle.
  - At lat_cnt==0, register mem_rdata >> (8*addr[1:0]), masked to access width, then go to DONE.
- DONE (one cycle): the owner's ready pulses with its rdata/err; go to IDLE.
- Handshake:
  - rdata/err are valid only in the ready cycle.
  - A requester may change or drop its req in the cycle after ready.
- Latency:
  - Req seen in IDLE at cycle 0 → load/fetch ready at cycle 2+LATENCY; store ready at cycle 2; misaligned ready at cycle 1.
  - One idle cycle separates back-to-back transactions.
- Fairness (fair_cnt):
  - Increments on each data grant while if_req=1 (saturates at FAIR_LIMIT).
  - Clears on a fetch grant or when if_req=0 in IDLE.
- Only one transaction is ever outstanding; a request arriving mid-transaction waits for IDLE.

Decomposition:
- Shared package mem_port_pkg holds:
  - State enum and owner enum {OWN_IF, OWN_D}.
  - Size funct3 constants, matching the load/store funct3 codes used by the MEM stage.
- One combinational sub-module, mem_lane_align: (addr[1:0], funct3, wdata, rdata) → (be, wdata_rep, rdata_shifted, misaligned). It is reused by the MEM stage later.

Test Plan:
- Fetch alone (LATENCY=2): if_req=1, if_addr=0x100 at cycle 0 → mem_req at 1 with mem_addr=0x100, be=1111; mem_rdata=0x00500093 at 3 → if_ready at 4, if_rdata=0x00500093.
- Contention: if_req and d_req (LW 0x200) both high at cycle 0 → data issued at 1 and d_ready at 4; fetch issued at 6, if_ready at 9; stall_if high for cycles 0–8.
- SB store: addr=0x203, wdata=0x000000AB, funct3=000 → mem_addr=0x200, be=1000, mem_wdata=0xABABABAB, mem_we=1 at 1; d_ready at 2.
- LH load: addr=0x102, funct3=001, mem_rdata=0xBEEF1234 → d_rdata=0x0000BEEF, d_err=0.
- Misaligned LW: addr=0x101, funct3=010 → no mem_req; d_ready and d_err at cycle 1, d_rdata=0. Then reset=0 during WAIT of a fetch → no if_ready, all outputs 0, FSM in IDLE.
- Fairness: d_req held with 6 back-to-back loads while if_req held → grant order D,D,D,D,IF,D,D.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the unified-memory port arbiter and lane steering.
package mem_port_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Access width decoded from funct3.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_t;

    // Load/store funct3 codes as used by the MEM stage.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic size_t decode_size(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            F3_LW:         return SZ_WORD;
            default:       return SZ_BAD;
        endcase
    endfunction

    // Memory is addressed by word; the low two bits select a lane instead.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Sub-word lane steering: byte enables, store replication, load right-shift and
// alignment check. Purely combinational so the MEM stage can reuse it directly.
module mem_lane_align
    import mem_port_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_shifted,
    output logic        misaligned
);

    logic [31:0] shifted;

    // Decode size, then steer lanes; illegal sizes are reported as misaligned.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a
        // value unassigned, which would otherwise infer a latch.
        shifted       = rdata >> {addr_lo, 3'b000};
        be            = 4'b0000;
        wdata_rep     = wdata;
        rdata_shifted = '0;
        misaligned    = 1'b0;
        case (decode_size(funct3))
            SZ_BYTE: begin
                be            = 4'b0001 << addr_lo;
                wdata_rep     = {4{wdata[7:0]}};
                rdata_shifted = {24'b0, shifted[7:0]};
            end
            SZ_HALF: begin
                misaligned    = addr_lo[0];
                be            = 4'b0011 << addr_lo;
                wdata_rep     = {2{wdata[15:0]}};
                rdata_shifted = {16'b0, shifted[15:0]};
            end
            SZ_WORD: begin
                misaligned    = |addr_lo;
                be            = 4'b1111;
                rdata_shifted = shifted;
            end
            default: begin
                misaligned    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported fixed-latency memory between instruction fetch
// and MEM-stage data accesses. Data has priority; a fairness counter forces a
// fetch grant after FAIR_LIMIT consecutive data grants with fetch waiting.
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int FAIR_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);

    state_t            state;
    owner_t            owner;
    logic [FAIR_W-1:0] fair_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              acc_we;
    logic [1:0]        acc_addr_lo;
    logic [2:0]        acc_f3;

    logic [1:0]  align_addr_lo;
    logic [2:0]  align_f3;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_rdata;
    logic        align_misaligned;
    logic        fetch_forced;

    // In IDLE the aligner looks at the incoming data request; afterwards it
    // uses the latched access so the returning word is shifted correctly.
    assign align_addr_lo = (state == ST_IDLE) ? d_addr[1:0] : acc_addr_lo;
    assign align_f3      = (state == ST_IDLE) ? d_funct3    : acc_f3;

    mem_lane_align u_align (
        .addr_lo       (align_addr_lo),
        .funct3        (align_f3),
        .wdata         (d_wdata),
        .rdata         (mem_rdata),
        .be            (align_be),
        .wdata_rep     (align_wdata),
        .rdata_shifted (align_rdata),
        .misaligned    (align_misaligned)
    );

    assign fetch_forced = if_req && (fair_cnt == FAIR_W'(FAIR_LIMIT));
    assign stall_if     = if_req && !if_ready;
    assign stall_mem    = d_req && !d_ready;

    // Transaction FSM with registered memory strobes, ready pulses and read data.
    always_ff @(posedge clock) begin
        // NOTE: all state here uses non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state       <= ST_IDLE;
            owner       <= OWN_IF;
            fair_cnt    <= '0;
            lat_cnt     <= '0;
            acc_we      <= 1'b0;
            acc_addr_lo <= 2'b00;
            acc_f3      <= 3'b000;
            if_ready    <= 1'b0;
            if_rdata    <= '0;
            d_ready     <= 1'b0;
            d_rdata     <= '0;
            d_err       <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= 4'b0000;
        end else begin
            // Pulses and per-cycle strobes drop unless re-asserted below.
            if_ready  <= 1'b0;
            if_rdata  <= '0;
            d_ready   <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;

            case (state)
                ST_IDLE: begin
                    if (d_req && !fetch_forced) begin
                        owner <= OWN_D;
                        if (!if_req) begin
                            fair_cnt <= '0;
                        end else if (fair_cnt != FAIR_W'(FAIR_LIMIT)) begin
                            fair_cnt <= fair_cnt + FAIR_W'(1);
                        end
                        if (align_misaligned) begin
                            // Rejected without touching memory.
                            state   <= ST_DONE;
                            d_ready <= 1'b1;
                            d_err   <= 1'b1;
                        end else begin
                            state       <= ST_ISSUE;
                            mem_req     <= 1'b1;
                            mem_we      <= d_we;
                            mem_addr    <= word_addr(d_addr);
                            mem_be      <= align_be;
                            mem_wdata   <= d_we ? align_wdata : 32'h0;
                            acc_we      <= d_we;
                            acc_addr_lo <= d_addr[1:0];
                            acc_f3      <= d_funct3;
                        end
                    end else if (if_req) begin
                        owner       <= OWN_IF;
                        fair_cnt    <= '0;
                        state       <= ST_ISSUE;
                        mem_req     <= 1'b1;
                        mem_addr    <= word_addr(if_addr);
                        mem_be      <= 4'b1111;
                        acc_we      <= 1'b0;
                        acc_addr_lo <= 2'b00;
                        acc_f3      <= F3_LW;
                    end else begin
                        fair_cnt <= '0;
                    end
                end

                ST_ISSUE: begin
                    if (acc_we) begin
                        // Posted write: complete without waiting on memory.
                        state   <= ST_DONE;
                        d_ready <= 1'b1;
                    end else begin
                        state   <= ST_WAIT;
                        lat_cnt <= LAT_W'(LATENCY - 1);
                    end
                end

                ST_WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= ST_DONE;
                        if (owner == OWN_D) begin
                            d_ready <= 1'b1;
                            d_rdata <= align_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= align_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model.
module tb_mem_port_arbiter;

    localparam int LATENCY    = 2;
    localparam int FAIR_LIMIT = 4;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] rd_word  = 32'h0;
    int          rd_cnt   = 0;

    mem_port_arbiter #(.LATENCY(LATENCY), .FAIR_LIMIT(FAIR_LIMIT)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_funct3  (d_funct3),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory returns rd_word only in the cycle LATENCY after a read strobe.
    always @(posedge clock) begin
        #1;
        mem_rdata = 32'h5A5A_5A5A;
        if (rd_cnt > 0) begin
            rd_cnt = rd_cnt - 1;
            if (rd_cnt == 0) mem_rdata = rd_word;
        end
        if (mem_req && !mem_we) rd_cnt = LATENCY;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Next cycle: wait for the falling edge, then let drives settle.
    task automatic next_cycle();
        @(negedge clock);
        #1;
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_if_ready"},  if_ready,  0);
        check({pfx, "_if_rdata"},  if_rdata,  0);
        check({pfx, "_d_ready"},   d_ready,   0);
        check({pfx, "_d_rdata"},   d_rdata,   0);
        check({pfx, "_d_err"},     d_err,     0);
        check({pfx, "_mem_req"},   mem_req,   0);
        check({pfx, "_mem_we"},    mem_we,    0);
        check({pfx, "_mem_addr"},  mem_addr,  0);
        check({pfx, "_mem_wdata"}, mem_wdata, 0);
        check({pfx, "_mem_be"},    {28'b0, mem_be}, 0);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word);
        @(negedge clock);
        if_req = 1'b1; if_addr = addr; rd_word = word;
        #1;
        check("f_stall_c0", stall_if, 1);
        next_cycle();
        check("f_mreq_c1", mem_req, 1);
        check("f_maddr_c1", mem_addr, addr);
        check("f_mbe_c1", {28'b0, mem_be}, 32'hF);
        check("f_mwe_c1", mem_we, 0);
        next_cycle();
        check("f_mreq_c2", mem_req, 0);
        next_cycle();
        check("f_rdy_c3", if_ready, 0);
        next_cycle();
        check("f_rdy_c4", if_ready, 1);
        check("f_rdata_c4", if_rdata, word);
        check("f_stall_c4", stall_if, 0);
        if_req = 1'b0;
        next_cycle();
        check("f_rdy_c5", if_ready, 0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b1; d_addr = addr; d_wdata = wd; d_funct3 = f3;
        next_cycle();
        check("st_mreq", mem_req, 1);
        check("st_mwe", mem_we, 1);
        check("st_maddr", mem_addr, addr & ~32'h3);
        check("st_mbe", {28'b0, mem_be}, {28'b0, exp_be});
        check("st_mwdata", mem_wdata, exp_wd);
        check("st_rdy_c1", d_ready, 0);
        next_cycle();
        check("st_rdy_c2", d_ready, 1);
        check("st_err", d_err, 0);
        check("st_mreq_c2", mem_req, 0);
        d_req = 1'b0; d_we = 1'b0;
        next_cycle();
        check("st_rdy_c3", d_ready, 0);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] word, input logic [31:0] exp);
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b0; d_addr = addr; d_funct3 = f3; rd_word = word;
        #1;
        check("ld_stall_c0", stall_mem, 1);
        next_cycle();
        check("ld_mreq", mem_req, 1);
        check("ld_mwe", mem_we, 0);
        check("ld_maddr", mem_addr, addr & ~32'h3);
        next_cycle();
        next_cycle();
        check("ld_rdy_c3", d_ready, 0);
        next_cycle();
        check("ld_rdy_c4", d_ready, 1);
        check("ld_rdata", d_rdata, exp);
        check("ld_err", d_err, 0);
        d_req = 1'b0;
        next_cycle();
        check("ld_rdy_c5", d_ready, 0);
        check("ld_rdata_c5", d_rdata, 0);
    endtask

    task automatic do_misaligned(input logic [31:0] addr, input logic [2:0] f3);
        @(negedge clock);
        d_req = 1'b1; d_we = 1'b0; d_addr = addr; d_funct3 = f3; d_wdata = 32'hFFFF_FFFF;
        next_cycle();
        check("mis_rdy", d_ready, 1);
        check("mis_err", d_err, 1);
        check("mis_rdata", d_rdata, 0);
        check("mis_mreq", mem_req, 0);
        d_req = 1'b0;
        next_cycle();
        check("mis_rdy_c2", d_ready, 0);
        check("mis_err_c2", d_err, 0);
        check("mis_mreq_c2", mem_req, 0);
    endtask

    initial begin
        logic [31:0] grant_q[$];
        logic [31:0] exp_order [7];
        int          d_done;
        bit          f_done;
        bit          fin;

        reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_funct3 = '0; mem_rdata = '0;
        next_cycle();
        next_cycle();
        check_quiet("rst");
        reset = 1'b1;
        next_cycle();

        // Fetch alone.
        do_fetch(32'h100, 32'h0050_0093);

        // Contention: data wins first, fetch follows after one idle cycle.
        for (int c = 0; c <= 9; c++) begin
            @(negedge clock);
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h100;
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_funct3 = 3'b010;
                rd_word = 32'h1122_3344;
            end
            if (c == 5) rd_word = 32'hCAFE_F00D;
            #1;
            check($sformatf("ct_stall_if_c%0d", c), stall_if, (c <= 8) ? 1 : 0);
            case (c)
                1: begin
                    check("ct_mreq_c1", mem_req, 1);
                    check("ct_maddr_c1", mem_addr, 32'h200);
                end
                4: begin
                    check("ct_drdy_c4", d_ready, 1);
                    check("ct_drdata_c4", d_rdata, 32'h1122_3344);
                    check("ct_ifrdy_c4", if_ready, 0);
                    d_req = 1'b0;
                end
                5: check("ct_mreq_c5", mem_req, 0);
                6: begin
                    check("ct_mreq_c6", mem_req, 1);
                    check("ct_maddr_c6", mem_addr, 32'h100);
                end
                9: begin
                    check("ct_ifrdy_c9", if_ready, 1);
                    check("ct_ifrdata_c9", if_rdata, 32'hCAFE_F00D);
                    if_req = 1'b0;
                end
                default: ;
            endcase
        end

        // Stores: byte, half, word lane steering.
        do_store(32'h203, 32'h0000_00AB, 3'b000, 4'b1000, 32'hABAB_ABAB);
        do_store(32'h200, 32'h0000_0055, 3'b000, 4'b0001, 32'h5555_5555);
        do_store(32'h202, 32'hCDEF_1234, 3'b001, 4'b1100, 32'h1234_1234);
        do_store(32'h204, 32'hDEAD_BEEF, 3'b010, 4'b1111, 32'hDEAD_BEEF);

        // Loads: right-aligned and masked, never extended.
        do_load(32'h102, 3'b001, 32'hBEEF_1234, 32'h0000_BEEF);
        do_load(32'h101, 3'b000, 32'hBEEF_1234, 32'h0000_0012);
        do_load(32'h103, 3'b100, 32'hBEEF_1234, 32'h0000_00BE);
        do_load(32'h100, 3'b101, 32'hBEEF_1234, 32'h0000_1234);
        do_load(32'h104, 3'b010, 32'h8765_4321, 32'h8765_4321);

        // Misaligned and illegal sizes.
        do_misaligned(32'h101, 3'b010);
        do_misaligned(32'h102, 3'b010);
        do_misaligned(32'h103, 3'b101);
        do_misaligned(32'h100, 3'b011);
        do_misaligned(32'h100, 3'b111);

        // Reset during WAIT of a fetch abandons it.
        @(negedge clock);
        if_req = 1'b1; if_addr = 32'h140; rd_word = 32'h1357_9BDF;
        next_cycle();
        check("rw_mreq_c1", mem_req, 1);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        check_quiet("rw");
        reset = 1'b1; if_req = 1'b0;
        for (int c = 4; c <= 7; c++) begin
            next_cycle();
            check($sformatf("rw_ifrdy_c%0d", c), if_ready, 0);
            check($sformatf("rw_mreq_c%0d", c), mem_req, 0);
        end
        // Arbiter must be back in IDLE: a fresh fetch has normal timing.
        do_fetch(32'h180, 32'h0246_8ACE);

        // Fairness: data held for 6 loads with fetch pending.
        exp_order = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h100, 32'h310, 32'h314};
        rd_word = 32'h0;
        d_done  = 0;
        f_done  = 1'b0;
        fin     = 1'b0;
        @(negedge clock);
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_funct3 = 3'b010;
        for (int c = 0; c < 200 && !fin; c++) begin
            next_cycle();
            if (mem_req) grant_q.push_back(mem_addr);
            if (d_ready) begin
                d_done++;
                d_addr = d_addr + 32'h4;
                if (d_done == 6) d_req = 1'b0;
            end
            if (if_ready) begin
                f_done = 1'b1;
                if_req = 1'b0;
            end
            fin = (d_done == 6) && f_done;
        end
        check("fair_finished", {31'b0, fin}, 1);
        check("fair_grants", grant_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("fair_order%0d", i),
                  (i < grant_q.size()) ? grant_q[i] : 32'hFFFF_FFFF, exp_order[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
